// File: rtl/dot_pkg.sv
// Shared constants, 5x7 font table and FSM encoding for the scrolling dot-matrix feeder.
package dot_pkg;

  localparam int unsigned FONT_COLS = 5;
  localparam int unsigned GAP_COLS  = 1;
  localparam int unsigned DISP_COLS = 10;
  localparam int unsigned ROW_BITS  = 7;

  localparam logic [3:0] CH_DASH  = 4'd10;
  localparam logic [3:0] CH_COLON = 4'd11;
  localparam logic [3:0] CH_BLANK = 4'd12;

  typedef logic [ROW_BITS-1:0] row_t;

  // Indexed [code][column]; bit0 of each entry is the top row.
  localparam row_t FONT [16][FONT_COLS] = '{
    '{7'h3E, 7'h51, 7'h49, 7'h45, 7'h3E},
    '{7'h00, 7'h42, 7'h7F, 7'h40, 7'h00},
    '{7'h42, 7'h61, 7'h51, 7'h49, 7'h46},
    '{7'h21, 7'h41, 7'h45, 7'h4B, 7'h31},
    '{7'h18, 7'h14, 7'h12, 7'h7F, 7'h10},
    '{7'h27, 7'h45, 7'h45, 7'h45, 7'h39},
    '{7'h3C, 7'h4A, 7'h49, 7'h49, 7'h30},
    '{7'h01, 7'h71, 7'h09, 7'h05, 7'h03},
    '{7'h36, 7'h49, 7'h49, 7'h49, 7'h36},
    '{7'h06, 7'h49, 7'h49, 7'h29, 7'h1E},
    '{7'h08, 7'h08, 7'h08, 7'h08, 7'h08},
    '{7'h00, 7'h36, 7'h36, 7'h00, 7'h00},
    '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00},
    '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00},
    '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00},
    '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00}
  };

  typedef enum logic {StIdle, StGlyph} state_e;

endpackage

// File: rtl/dot_font_rom.sv
// Combinational 5x7 glyph lookup: one column word per (code, column).
module dot_font_rom
  import dot_pkg::*;
(
  input  logic [3:0] code_i,
  input  logic [2:0] col_i,
  output logic [6:0] row_o
);

  always_comb begin
    row_o = '0;
    if (code_i < CH_BLANK && col_i < 3'(FONT_COLS)) begin
      row_o = FONT[code_i][col_i];
    end
  end

endmodule

// File: rtl/dot_scroll_gen.sv
// Queues character codes and scrolls their glyphs right-to-left across ten column words.
module dot_scroll_gen
  import dot_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 1000000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       clr,
  input  logic       char_valid,
  input  logic [3:0] char_code,
  output logic       char_ready,
  output logic       busy,
  output logic [6:0] dot_data_00,
  output logic [6:0] dot_data_01,
  output logic [6:0] dot_data_02,
  output logic [6:0] dot_data_03,
  output logic [6:0] dot_data_04,
  output logic [6:0] dot_data_05,
  output logic [6:0] dot_data_06,
  output logic [6:0] dot_data_07,
  output logic [6:0] dot_data_08,
  output logic [6:0] dot_data_09
);

  localparam int unsigned CntW    = $clog2(TICK_DIV);
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam logic [2:0]  LastCol = 3'(FONT_COLS + GAP_COLS - 1);

  logic [CntW-1:0] cnt_d, cnt_q;
  logic [AW:0]     wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [3:0]      mem_q [FIFO_DEPTH];
  state_e          state_d, state_q;
  logic [2:0]      col_idx_d, col_idx_q;
  logic [3:0]      cur_code_d, cur_code_q;
  row_t            disp_d [DISP_COLS];
  row_t            disp_q [DISP_COLS];

  logic       tick, full, empty, push, pop;
  logic [3:0] head, rom_code;
  logic [2:0] rom_col;
  row_t       rom_row, nc;

  assign tick       = (cnt_q == CntLast);
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign char_ready = !full;
  assign push       = char_valid & char_ready;
  assign busy       = (state_q == StGlyph) | !empty;
  assign head       = mem_q[rd_ptr_q[AW-1:0]];

  // In IDLE the ROM looks at the FIFO head so column 0 is ready on the popping tick.
  assign rom_code = (state_q == StIdle) ? head : cur_code_q;
  assign rom_col  = (state_q == StIdle) ? 3'd0 : col_idx_q;

  dot_font_rom u_font (
    .code_i(rom_code),
    .col_i (rom_col),
    .row_o (rom_row)
  );

  always_comb begin
    state_d    = state_q;
    col_idx_d  = col_idx_q;
    cur_code_d = cur_code_q;
    disp_d     = disp_q;
    pop        = 1'b0;
    nc         = '0;
    cnt_d      = tick ? '0 : cnt_q + CntW'(1);

    if (tick) begin
      unique case (state_q)
        StIdle: begin
          if (!empty) begin
            pop        = 1'b1;
            cur_code_d = head;
            nc         = rom_row;
            col_idx_d  = 3'd1;
            state_d    = StGlyph;
          end
        end
        StGlyph: begin
          if (col_idx_q == LastCol) begin
            col_idx_d = 3'd0;
            state_d   = StIdle;
          end else begin
            nc        = rom_row;
            col_idx_d = col_idx_q + 3'd1;
          end
        end
      endcase
      for (int i = 0; i < DISP_COLS - 1; i++) begin
        disp_d[i] = disp_q[i+1];
      end
      disp_d[DISP_COLS-1] = nc;
    end

    wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);

    if (clr) begin
      state_d    = StIdle;
      col_idx_d  = '0;
      cur_code_d = '0;
      cnt_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      for (int i = 0; i < DISP_COLS; i++) begin
        disp_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      state_q    <= StIdle;
      col_idx_q  <= '0;
      cur_code_q <= '0;
      for (int i = 0; i < DISP_COLS; i++) begin
        disp_q[i] <= '0;
      end
    end else begin
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      state_q    <= state_d;
      col_idx_q  <= col_idx_d;
      cur_code_q <= cur_code_d;
      disp_q     <= disp_d;
    end
  end

  // Storage needs no reset: pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= char_code;
    end
  end

  assign dot_data_00 = disp_q[0];
  assign dot_data_01 = disp_q[1];
  assign dot_data_02 = disp_q[2];
  assign dot_data_03 = disp_q[3];
  assign dot_data_04 = disp_q[4];
  assign dot_data_05 = disp_q[5];
  assign dot_data_06 = disp_q[6];
  assign dot_data_07 = disp_q[7];
  assign dot_data_08 = disp_q[8];
  assign dot_data_09 = disp_q[9];

endmodule

// File: tb/tb_dot_scroll_gen.sv
// Directed bench: instance A (TICK_DIV=4) for scrolling/reset, instance B (TICK_DIV=16) for fill/clr.
module tb_dot_scroll_gen;

  logic       clk, nreset;
  logic       a_clr, a_valid, a_ready, a_busy;
  logic [3:0] a_code;
  logic [6:0] a_d [10];
  logic       b_clr, b_valid, b_ready, b_busy;
  logic [3:0] b_code;
  logic [6:0] b_d [10];

  int checks = 0;
  int errors = 0;

  dot_scroll_gen #(.TICK_DIV(4), .FIFO_DEPTH(4)) u_dut_a (
    .clk(clk), .nreset(nreset), .clr(a_clr), .char_valid(a_valid), .char_code(a_code),
    .char_ready(a_ready), .busy(a_busy),
    .dot_data_00(a_d[0]), .dot_data_01(a_d[1]), .dot_data_02(a_d[2]), .dot_data_03(a_d[3]),
    .dot_data_04(a_d[4]), .dot_data_05(a_d[5]), .dot_data_06(a_d[6]), .dot_data_07(a_d[7]),
    .dot_data_08(a_d[8]), .dot_data_09(a_d[9])
  );

  dot_scroll_gen #(.TICK_DIV(16), .FIFO_DEPTH(4)) u_dut_b (
    .clk(clk), .nreset(nreset), .clr(b_clr), .char_valid(b_valid), .char_code(b_code),
    .char_ready(b_ready), .busy(b_busy),
    .dot_data_00(b_d[0]), .dot_data_01(b_d[1]), .dot_data_02(b_d[2]), .dot_data_03(b_d[3]),
    .dot_data_04(b_d[4]), .dot_data_05(b_d[5]), .dot_data_06(b_d[6]), .dot_data_07(b_d[7]),
    .dot_data_08(b_d[8]), .dot_data_09(b_d[9])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_a();
    a_clr = 1'b1;
    step(1);
    a_clr = 1'b0;
  endtask

  task automatic clr_b();
    b_clr = 1'b1;
    step(1);
    b_clr = 1'b0;
  endtask

  task automatic test_reset();
    nreset = 1'b1;
    #2 nreset = 1'b0;
    #1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (a_d[i] !== 7'h00) begin
        errors++;
        $display("FAIL reset_d%0d: got %h want 00", i, a_d[i]);
      end
    end
    checks++;
    if (a_ready !== 1'b1 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: ready=%b busy=%b want ready=1 busy=0", a_ready, a_busy);
    end
    step(1);
    #2 nreset = 1'b1;
    step(40);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (a_d[i] !== 7'h00) begin
        errors++;
        $display("FAIL idle40_d%0d: got %h want 00", i, a_d[i]);
      end
    end
    checks++;
    if (a_ready !== 1'b1 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle40_flags: ready=%b busy=%b want ready=1 busy=0", a_ready, a_busy);
    end
  endtask

  task automatic test_dash();
    clr_a();
    a_code  = 4'd10;
    a_valid = 1'b1;
    step(1);
    a_valid = 1'b0;
    checks++;
    if (a_busy !== 1'b1) begin
      errors++;
      $display("FAIL dash_busy_c1: got %b want 1", a_busy);
    end
    step(3);
    checks++;
    if (a_d[9] !== 7'h08) begin
      errors++;
      $display("FAIL dash_tick1_d09: got %h want 08", a_d[9]);
    end
    step(16);
    for (int i = 5; i < 10; i++) begin
      checks++;
      if (a_d[i] !== 7'h08) begin
        errors++;
        $display("FAIL dash_tick5_d%0d: got %h want 08", i, a_d[i]);
      end
    end
    checks++;
    if (a_d[4] !== 7'h00) begin
      errors++;
      $display("FAIL dash_tick5_d04: got %h want 00", a_d[4]);
    end
    step(3);
    checks++;
    if (a_busy !== 1'b1) begin
      errors++;
      $display("FAIL dash_busy_pre6: got %b want 1", a_busy);
    end
    step(1);
    checks++;
    if (a_d[9] !== 7'h00 || a_d[8] !== 7'h08 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL dash_tick6: d09=%h d08=%h busy=%b want 00 08 0", a_d[9], a_d[8], a_busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp8 [10];
    logic [6:0] exp10 [10];
    exp8  = '{7'h00, 7'h00, 7'h3E, 7'h51, 7'h49, 7'h45, 7'h3E, 7'h00, 7'h00, 7'h42};
    exp10 = '{7'h3E, 7'h51, 7'h49, 7'h45, 7'h3E, 7'h00, 7'h00, 7'h42, 7'h7F, 7'h40};
    clr_a();
    a_code  = 4'd0;
    a_valid = 1'b1;
    step(1);
    a_code = 4'd1;
    step(1);
    a_valid = 1'b0;
    step(30);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (a_d[i] !== exp8[i]) begin
        errors++;
        $display("FAIL b2b_tick8_d%0d: got %h want %h", i, a_d[i], exp8[i]);
      end
    end
    step(8);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (a_d[i] !== exp10[i]) begin
        errors++;
        $display("FAIL b2b_tick10_d%0d: got %h want %h", i, a_d[i], exp10[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    clr_a();
    a_code  = 4'd0;
    a_valid = 1'b1;
    step(1);
    a_valid = 1'b0;
    step(11);
    checks++;
    if (a_d[9] !== 7'h49 || a_d[8] !== 7'h51 || a_d[7] !== 7'h3E) begin
      errors++;
      $display("FAIL ares_pre: d07..09=%h %h %h want 3E 51 49", a_d[7], a_d[8], a_d[9]);
    end
    #3 nreset = 1'b0;
    #1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (a_d[i] !== 7'h00) begin
        errors++;
        $display("FAIL ares_d%0d: got %h want 00", i, a_d[i]);
      end
    end
    checks++;
    if (a_ready !== 1'b1 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL ares_flags: ready=%b busy=%b want ready=1 busy=0", a_ready, a_busy);
    end
    #2 nreset = 1'b1;
    a_code  = 4'd1;
    a_valid = 1'b1;
    step(1);
    a_valid = 1'b0;
    step(7);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (a_d[i] !== ((i == 9) ? 7'h42 : 7'h00)) begin
        errors++;
        $display("FAIL ares_resume_d%0d: got %h want %h", i, a_d[i],
                 (i == 9) ? 7'h42 : 7'h00);
      end
    end
  endtask

  task automatic test_fill();
    logic [6:0] seq [30];
    seq = '{7'h42, 7'h61, 7'h51, 7'h49, 7'h46, 7'h00,
            7'h21, 7'h41, 7'h45, 7'h4B, 7'h31, 7'h00,
            7'h18, 7'h14, 7'h12, 7'h7F, 7'h10, 7'h00,
            7'h27, 7'h45, 7'h45, 7'h45, 7'h39, 7'h00,
            7'h3C, 7'h4A, 7'h49, 7'h49, 7'h30, 7'h00};
    clr_b();
    b_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      b_code = 4'(2 + k);
      step(1);
    end
    b_code = 4'd6;
    checks++;
    if (b_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_ready_full: got %b want 0", b_ready);
    end
    step(11);
    checks++;
    if (b_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_ready_held: got %b want 0", b_ready);
    end
    step(1);
    checks++;
    if (b_ready !== 1'b1 || b_d[9] !== seq[0]) begin
      errors++;
      $display("FAIL fill_first_pop: ready=%b d09=%h want 1 %h", b_ready, b_d[9], seq[0]);
    end
    step(1);
    b_valid = 1'b0;
    for (int t = 1; t < 30; t++) begin
      step((t == 1) ? 15 : 16);
      checks++;
      if (b_d[9] !== seq[t]) begin
        errors++;
        $display("FAIL fill_tick%0d_d09: got %h want %h", t + 1, b_d[9], seq[t]);
      end
    end
    checks++;
    if (b_busy !== 1'b0) begin
      errors++;
      $display("FAIL fill_busy_end: got %b want 0", b_busy);
    end
  endtask

  task automatic test_clr();
    clr_b();
    b_code  = 4'd8;
    b_valid = 1'b1;
    step(4);
    b_valid = 1'b0;
    step(12);
    b_code  = 4'd9;
    b_valid = 1'b1;
    step(1);
    b_valid = 1'b0;
    step(15);
    checks++;
    if (b_d[9] !== 7'h49 || b_d[8] !== 7'h36 || b_busy !== 1'b1 || b_ready !== 1'b0) begin
      errors++;
      $display("FAIL clr_pre: d09=%h d08=%h busy=%b ready=%b want 49 36 1 0",
               b_d[9], b_d[8], b_busy, b_ready);
    end
    step(2);
    b_clr   = 1'b1;
    b_code  = 4'd1;
    b_valid = 1'b1;
    step(1);
    b_clr   = 1'b0;
    b_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (b_d[i] !== 7'h00) begin
        errors++;
        $display("FAIL clr_d%0d: got %h want 00", i, b_d[i]);
      end
    end
    checks++;
    if (b_busy !== 1'b0 || b_ready !== 1'b1) begin
      errors++;
      $display("FAIL clr_flags: busy=%b ready=%b want 0 1", b_busy, b_ready);
    end
    for (int t = 0; t < 8; t++) begin
      step(16);
      checks++;
      if (b_d[9] !== 7'h00 || b_busy !== 1'b0) begin
        errors++;
        $display("FAIL clr_after_tick%0d: d09=%h busy=%b want 00 0", t, b_d[9], b_busy);
      end
    end
  endtask

  initial begin
    nreset  = 1'b1;
    a_clr   = 1'b0;
    a_valid = 1'b0;
    a_code  = 4'd0;
    b_clr   = 1'b0;
    b_valid = 1'b0;
    b_code  = 4'd0;
    test_reset();
    test_dash();
    test_back_to_back();
    test_async_reset();
    test_fill();
    test_clr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
